mux_nx1_pipe: RTL and testbench
===============================

MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel and of the output, at least 1.
REQ-002 Parameter N, default 4, number of input channels, 2..16.
REQ-003 Parameter SELW is derived as clog2(N), minimum 1, and is not user-overridable.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port in_data, input, N*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, N, per-channel valid.
REQ-008 Port in_ready, output, N, per-channel ready; at most one bit high in any cycle.
REQ-009 Port sel, input, SELW, channel select used in fixed mode.
REQ-010 Port mode, input, 1: 0 = fixed select, 1 = round-robin.
REQ-011 Port out_data, output, WIDTH, head-entry data.
REQ-012 Port out_src, output, SELW, channel index of the head entry.
REQ-013 Port out_valid, output, 1, head entry present.
REQ-014 Port out_ready, input, 1, downstream accepts the head entry.

Function
REQ-015 Internal storage SHALL be a 2-entry FIFO (output register plus skid entry) holding {data, src}, with occupancy count 0..2.
REQ-016 space SHALL equal (count < 2), evaluated on the registered count before this cycle's pop.
REQ-017 A channel transfer SHALL occur when in_valid[g] && in_ready[g]; a pop SHALL occur when out_valid && out_ready.
REQ-018 Fixed mode: grant g = sel; in_ready[sel] = space; all other in_ready bits = 0.
REQ-019 Fixed mode, sel >= N: all in_ready = 0 and no transfer occurs.
REQ-020 Round-robin mode: g SHALL be the first i with in_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo N; in_ready[g] = space; all other bits = 0; if no channel is valid, all bits = 0.
REQ-021 in_ready MAY depend combinationally on in_valid, sel, mode and registered state only; it SHALL NOT depend on out_ready.
REQ-022 On a round-robin transfer, rr_ptr SHALL become (g+1) mod N; otherwise, including in fixed mode, rr_ptr SHALL hold.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-024 Latency SHALL be 1 cycle: a word accepted at edge k appears on out_data at edge k when count was 0, or after all older entries otherwise.
REQ-025 Sustained throughput SHALL be 1 word per cycle while out_ready = 1.
REQ-026 out_data and out_src SHALL hold stable while out_valid && !out_ready.
REQ-027 Changes to mode or sel SHALL affect only subsequent grants; buffered entries are unaffected.
REQ-028 When count = 0, out_data and out_src SHALL hold their last values (0 after reset).

Reset
REQ-029 While reset = 1 at a rising edge: count = 0, out_valid = 0, out_data = 0, out_src = 0, rr_ptr = 0, and the skid entry is cleared.
REQ-030 During a cycle with reset = 1, all in_ready bits SHALL be 0, and no transfer SHALL be recorded.
REQ-031 Reset asserted mid-stream SHALL discard both entries without emitting them.

Structure
REQ-032 Shared package mux_pkg SHALL hold the constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1, and the clog2 function.
REQ-033 Round-robin grant logic SHALL be a sub-module named rr_arbiter (N-way, inputs req and ptr, output grant index and grant valid).

Verification
REQ-034 The bench SHALL cover reset: assert reset with both entries full -> next cycle out_valid = 0, out_data = 0, rr_ptr = 0, in_ready = 0.
REQ-035 The bench SHALL cover fixed-mode streaming: N = 4, sel = 2, in_valid = 4'b1111, channel 2 data = 0xA0+k, out_ready = 1 -> out_data = 0xA0, 0xA1, ... on consecutive cycles, out_src = 2, and in_ready = 4'b0100.
REQ-036 The bench SHALL cover backpressure: out_ready = 0 for 3 cycles -> exactly 2 words accepted, then in_ready = 0; on release, words emerge in order with none lost or duplicated.
REQ-037 The bench SHALL cover round-robin fairness: mode = 1, all channels valid continuously, out_ready = 1 -> out_src sequence 0, 1, 2, 3, 0, 1, ...
REQ-038 The bench SHALL cover sparse round-robin: only channels 1 and 3 valid, rr_ptr = 2 -> grants 3, 1, 3, 1.
REQ-039 The bench SHALL cover an out-of-range select: N = 3, sel = 3, fixed mode -> in_ready = 0 and out_valid stays 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined N:1 mux.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2 for positive n; only used at elaboration time.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Select/source index width, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_pipe_rr_arbiter.sv
// N-way round-robin grant: picks the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  int idx;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        grant       = SELW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N:1 channel mux feeding a 2-entry output FIFO (output register + skid),
// with fixed-select or round-robin channel grant.
module mux_nx1_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [1:0]       count;
  logic [WIDTH-1:0] head_data;
  logic [SELW-1:0]  head_src;
  logic [WIDTH-1:0] skid_data;
  logic [SELW-1:0]  skid_src;
  logic [SELW-1:0]  rr_ptr;

  logic [SELW-1:0]  rr_grant;
  logic             rr_grant_valid;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             space;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic [SELW-1:0]  rr_ptr_nxt;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req         (in_valid),
    .ptr         (rr_ptr),
    .grant       (rr_grant),
    .grant_valid (rr_grant_valid)
  );

  // Space comes from the registered count only, so in_ready never sees out_ready.
  assign space = (count < 2'd2) && !reset;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end else begin
      grant       = sel;
      grant_valid = (int'(sel) < N);
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_valid && space) in_ready[grant] = 1'b1;
  end

  always_comb begin
    push_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) push_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign push = |(in_valid & in_ready);
  assign pop  = out_valid && out_ready;

  assign rr_ptr_nxt = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      head_data <= '0;
      head_src  <= '0;
      skid_data <= '0;
      skid_src  <= '0;
      rr_ptr    <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_data <= push_data;
            head_src  <= grant;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data <= push_data;
            head_src  <= grant;
          end else if (push) begin
            skid_data <= push_data;
            skid_src  <= grant;
            count     <= 2'd2;
          end else if (pop) begin
            count     <= 2'd0;
          end
        end
        default: begin
          // Full: no push can be granted, so only a pop advances the skid entry.
          if (pop) begin
            head_data <= skid_data;
            head_src  <= skid_src;
            count     <= 2'd1;
          end
        end
      endcase
      if (push && (mode == MODE_RR)) rr_ptr <= rr_ptr_nxt;
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = head_data;
  assign out_src   = head_src;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed self-checking bench for mux_nx1_pipe (N=4 and N=3 instances).
module tb_mux_nx1_pipe;

  logic clk = 1'b0;
  logic reset;

  logic [31:0] in_data4;
  logic [3:0]  in_valid4;
  logic [3:0]  in_ready4;
  logic [1:0]  sel4;
  logic        mode4;
  logic [7:0]  out_data4;
  logic [1:0]  out_src4;
  logic        out_valid4;
  logic        out_ready4;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [7:0]  out_data3;
  logic [1:0]  out_src3;
  logic        out_valid3;
  logic        out_ready3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_nx1_pipe #(.WIDTH(8), .N(4)) u4 (
    .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .sel(sel4), .mode(mode4), .out_data(out_data4),
    .out_src(out_src4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  mux_nx1_pipe #(.WIDTH(8), .N(3)) u3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid4 = '0;
    in_valid3 = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode4 = 1'b0; sel4 = 2'd0; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    in_data4 = 32'h13121110;
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1; in_data3 = 24'h323130;
    tick();
    total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL reset_rdy4 got=%b exp=%b", in_ready4, 4'b0000); end
    total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL reset_rdy3 got=%b exp=%b", in_ready3, 3'b000); end
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_vld4 got=%b exp=0", out_valid4); end
    total++; if (out_data4 !== 8'h00) begin bad++; $display("FAIL reset_data4 got=%h exp=00", out_data4); end
    total++; if (out_src4 !== 2'd0) begin bad++; $display("FAIL reset_src4 got=%0d exp=0", out_src4); end
    tick();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_notx4 got=%b exp=0", out_valid4); end
    total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL reset_notx3 got=%b exp=0", out_valid3); end
    reset = 1'b0; in_valid3 = '0; mode4 = 1'b1;
    #1;
    total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL reset_rrptr got=%b exp=%b", in_ready4, 4'b0001); end
    in_valid4 = '0;
    tick();
  endtask

  task automatic test_fixed_stream();
    do_reset();
    mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    in_data4 = 32'h13A01110;
    for (int k = 0; k < 6; k++) begin
      in_data4[23:16] = 8'(8'hA0 + k);
      #1;
      total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL fixed_rdy k=%0d got=%b exp=%b", k, in_ready4, 4'b0100); end
      tick();
      total++; if (out_valid4 !== 1'b1 || out_data4 !== 8'(8'hA0 + k) || out_src4 !== 2'd2) begin
        bad++; $display("FAIL fixed_out k=%0d got=%b/%h/%0d exp=1/%h/2", k, out_valid4, out_data4, out_src4, 8'(8'hA0 + k));
      end
    end
    in_valid4 = '0;
    tick();
    total++; if (out_valid4 !== 1'b0 || out_data4 !== 8'hA5) begin
      bad++; $display("FAIL fixed_drain got=%b/%h exp=0/a5", out_valid4, out_data4);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rdy [3] = '{4'b0100, 4'b0100, 4'b0000};
    int accepted = 0;
    do_reset();
    mode4 = 1'b0; sel4 = 2'd2; out_ready4 = 1'b0; in_valid4 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      in_data4[23:16] = 8'(8'hB0 + i);
      #1;
      total++; if (in_ready4 !== exp_rdy[i]) begin bad++; $display("FAIL bp_rdy i=%0d got=%b exp=%b", i, in_ready4, exp_rdy[i]); end
      if (in_ready4[2]) accepted++;
      tick();
      total++; if (out_valid4 !== 1'b1 || out_data4 !== 8'hB0) begin
        bad++; $display("FAIL bp_hold i=%0d got=%b/%h exp=1/b0", i, out_valid4, out_data4);
      end
    end
    total++; if (accepted != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", accepted); end
    out_ready4 = 1'b1; in_valid4 = 4'b0100;
    #1;
    total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL bp_rdy_full got=%b exp=0000", in_ready4); end
    in_valid4 = '0;
    tick();
    total++; if (out_valid4 !== 1'b1 || out_data4 !== 8'hB1) begin
      bad++; $display("FAIL bp_rel1 got=%b/%h exp=1/b1", out_valid4, out_data4);
    end
    tick();
    total++; if (out_valid4 !== 1'b0 || out_data4 !== 8'hB1) begin
      bad++; $display("FAIL bp_rel2 got=%b/%h exp=0/b1", out_valid4, out_data4);
    end
  endtask

  task automatic test_rr_fair();
    do_reset();
    mode4 = 1'b1; out_ready4 = 1'b1; in_data4 = 32'h53525150; in_valid4 = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (in_ready4 !== 4'(1 << (k % 4))) begin
        bad++; $display("FAIL rr_rdy k=%0d got=%b exp=%b", k, in_ready4, 4'(1 << (k % 4)));
      end
      tick();
      total++; if (out_src4 !== 2'(k % 4) || out_data4 !== 8'(8'h50 + k % 4)) begin
        bad++; $display("FAIL rr_out k=%0d got=%0d/%h exp=%0d/%h", k, out_src4, out_data4, k % 4, 8'(8'h50 + k % 4));
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [3:0] exp_rdy [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    logic [1:0] exp_src [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
    in_valid4 = 4'b1111;
    tick();
    tick();
    total++; if (out_src4 !== 2'd1) begin bad++; $display("FAIL sparse_pre got=%0d exp=1", out_src4); end
    in_valid4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (in_ready4 !== exp_rdy[i]) begin bad++; $display("FAIL sparse_rdy i=%0d got=%b exp=%b", i, in_ready4, exp_rdy[i]); end
      tick();
      total++; if (out_src4 !== exp_src[i]) begin bad++; $display("FAIL sparse_src i=%0d got=%0d exp=%0d", i, out_src4, exp_src[i]); end
    end
    in_valid4 = '0;
    tick();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL sparse_drain got=%b exp=0", out_valid4); end
  endtask

  task automatic test_reset_full();
    do_reset();
    mode4 = 1'b1; out_ready4 = 1'b0; in_data4 = 32'h53525150; in_valid4 = 4'b1111;
    tick();
    tick();
    total++; if (out_valid4 !== 1'b1 || in_ready4 !== 4'b0000 || out_data4 !== 8'h50) begin
      bad++; $display("FAIL rfull_pre got=%b/%b/%h exp=1/0000/50", out_valid4, in_ready4, out_data4);
    end
    reset = 1'b1;
    tick();
    total++; if (out_valid4 !== 1'b0 || out_data4 !== 8'h00 || out_src4 !== 2'd0) begin
      bad++; $display("FAIL rfull_clear got=%b/%h/%0d exp=0/00/0", out_valid4, out_data4, out_src4);
    end
    total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL rfull_rdy got=%b exp=0000", in_ready4); end
    reset = 1'b0;
    #1;
    total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL rfull_ptr got=%b exp=0001", in_ready4); end
    in_valid4 = '0; out_ready4 = 1'b1;
    tick();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL rfull_discard got=%b exp=0", out_valid4); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1; in_data3 = 24'h323130;
    #1;
    total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL oor_rdy got=%b exp=000", in_ready3); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL oor_vld i=%0d got=%b exp=0", i, out_valid3); end
    end
    sel3 = 2'd1;
    #1;
    total++; if (in_ready3 !== 3'b010) begin bad++; $display("FAIL oor_sel1_rdy got=%b exp=010", in_ready3); end
    tick();
    total++; if (out_valid3 !== 1'b1 || out_src3 !== 2'd1 || out_data3 !== 8'h31) begin
      bad++; $display("FAIL oor_sel1_out got=%b/%0d/%h exp=1/1/31", out_valid3, out_src3, out_data3);
    end
    in_valid3 = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    in_data4 = '0; in_valid4 = '0; sel4 = '0; mode4 = 1'b0; out_ready4 = 1'b0;
    in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b0;
    test_reset();
    test_fixed_stream();
    test_backpressure();
    test_rr_fair();
    test_rr_sparse();
    test_reset_full();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
